// File: rtl/sti_console.sv
// ============================================================================
//  sti_console -- STI responder exposing keyboard/display/machine-control regs
//  Rev 1.0
// ============================================================================
`default_nettype none

module sti_console #(
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        init_txn,
   input  logic        wtxn,
   input  logic [7:0]  addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        rdy,
   input  logic        kbd_valid,
   input  logic [7:0]  kbd_data,
   output logic        kbd_ready,
   output logic        dsp_valid,
   output logic [7:0]  dsp_data,
   input  logic        dsp_ready,
   output logic        kbd_irq,
   output logic        dsp_irq,
   output logic        mcr_ce
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   localparam logic [3:0] c_LAT     = 4'(LATENCY);
   localparam logic [7:0] c_A_KBSR  = 8'h00;
   localparam logic [7:0] c_A_KBDR  = 8'h01;
   localparam logic [7:0] c_A_DSR   = 8'h02;
   localparam logic [7:0] c_A_DDR   = 8'h03;
   localparam logic [7:0] c_A_MCR   = 8'hFF;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_rdy;
   logic        r_wtxn;
   logic [7:0]  r_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_rdata;

   logic        r_krdy;
   logic        r_kie;
   logic [7:0]  r_kbyte;
   logic        r_drdy;
   logic        r_die;
   logic [7:0]  r_dbyte;
   logic        r_mce;

   logic        w_wr;
   logic        w_rd;
   logic [15:0] w_rd_val;
   logic        w_unused_bits;

   assign w_wr = r_rdy &  r_wtxn;
   assign w_rd = r_rdy & ~r_wtxn;
   assign w_unused_bits = ^r_wdata[13:8];

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_rdy   <= 1'b0;
         r_wtxn  <= 1'b0;
         r_addr  <= 8'h00;
         r_wdata <= 16'h0000;
         r_rdata <= 16'h0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (init_txn) begin
                  r_wtxn  <= wtxn;
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  r_cnt   <= c_LAT;
                  r_rdy   <= (c_LAT == 4'd1);
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_rdy) begin
                  r_rdy   <= 1'b0;
                  r_state <= S_IDLE;
                  if (!r_wtxn) r_rdata <= w_rd_val;
               end else begin
                  // rdy is raised one edge early so it is high in cycle LATENCY
                  r_cnt <= r_cnt - 4'd1;
                  if (r_cnt == 4'd2) r_rdy <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_krdy  <= 1'b0;
         r_kie   <= 1'b0;
         r_kbyte <= 8'h00;
         r_drdy  <= 1'b1;
         r_die   <= 1'b0;
         r_dbyte <= 8'h00;
         r_mce   <= 1'b1;
      end else begin
         if (w_wr && r_addr == c_A_KBSR) r_kie <= r_wdata[14];
         if (w_rd && r_addr == c_A_KBDR) r_krdy <= 1'b0;
         // capture placed after the clear so a live handshake always wins
         if (kbd_valid && !r_krdy) begin
            r_krdy  <= 1'b1;
            r_kbyte <= kbd_data;
         end
         if (w_wr && r_addr == c_A_DSR) r_die <= r_wdata[14];
         if (w_wr && r_addr == c_A_DDR && r_drdy) begin
            r_dbyte <= r_wdata[7:0];
            r_drdy  <= 1'b0;
         end
         if (!r_drdy && dsp_ready) r_drdy <= 1'b1;
         if (w_wr && r_addr == c_A_MCR) r_mce <= r_wdata[15];
      end
   end

   always_comb begin
      w_rd_val = 16'h0000;
      case (r_addr)
         c_A_KBSR: w_rd_val = {r_krdy, r_kie, 14'h0000};
         c_A_KBDR: w_rd_val = {8'h00, r_kbyte};
         c_A_DSR:  w_rd_val = {r_drdy, r_die, 14'h0000};
         c_A_MCR:  w_rd_val = {r_mce, 15'h0000};
         default:  w_rd_val = 16'h0000;
      endcase
   end

   // Status is read live in the rdy cycle, then held until the next read
   assign rdata     = w_rd ? w_rd_val : r_rdata;
   assign rdy       = r_rdy;
   assign kbd_ready = ~r_krdy;
   assign dsp_valid = ~r_drdy;
   assign dsp_data  = r_dbyte;
   assign kbd_irq   = r_krdy & r_kie;
   assign dsp_irq   = r_drdy & r_die;
   assign mcr_ce    = r_mce;

endmodule

`default_nettype wire

// File: doc/sti_console.md
STI_CONSOLE -- requirements
Module: sti_console

Interface
REQ-001 Parameter LATENCY, default 1, cycles from accepted init_txn to rdy pulse; legal range 1..15.
REQ-002 clk  in  1  single system clock, all state updates on rising edge.
REQ-003 arst_n  in  1  asynchronous active-low reset.
REQ-004 init_txn  in  1  STI responder: transaction request pulse from master.
REQ-005 wtxn  in  1  1 = write, 0 = read; sampled with init_txn.
REQ-006 addr  in  8  word index into device page (0x00 KBSR, 0x01 KBDR, 0x02 DSR, 0x03 DDR, 0xFF MCR).
REQ-007 wdata  in  16  write data; sampled with init_txn.
REQ-008 rdata  out  16  read data, valid in rdy cycle, held until next rdy.
REQ-009 rdy  out  1  one-cycle transaction-complete pulse.
REQ-010 kbd_valid  in  1  keyboard byte offered.
REQ-011 kbd_data  in  8  keyboard byte.
REQ-012 kbd_ready  out  1  responder can accept keyboard byte.
REQ-013 dsp_valid  out  1  display byte pending.
REQ-014 dsp_data  out  8  pending display byte.
REQ-015 dsp_ready  in  1  display sink accepts byte.
REQ-016 kbd_irq, dsp_irq  out  1 each  interrupt requests.
REQ-017 mcr_ce  out  1  machine clock enable (MCR bit 15).

Function
REQ-018 FSM states IDLE, BUSY; init_txn in IDLE captures wtxn/addr/wdata, loads latency counter, enters BUSY.
REQ-019 rdy SHALL assert exactly LATENCY cycles after the accepted init_txn cycle, for one cycle, then FSM returns to IDLE.
REQ-020 init_txn while BUSY or in the rdy cycle SHALL be ignored (no capture, no extra rdy).
REQ-021 All register side effects SHALL commit on the clock edge ending the rdy cycle.
REQ-022 KBSR: bit15 KRDY read-only, bit14 KIE read/write, other bits read 0, write ignores all but bit14.
REQ-023 KBDR read returns {8'h00, kbd byte} and clears KRDY; write ignored.
REQ-024 DSR: bit15 DRDY read-only, bit14 DIE read/write, other bits read 0.
REQ-025 DDR write with DRDY=1 latches wdata[7:0] into dsp_data and clears DRDY; with DRDY=0 write dropped; read returns 0.
REQ-026 MCR: bit15 read/write, drives mcr_ce; other bits read 0.
REQ-027 Unmapped addr: read returns 0, write ignored, rdy still issued on schedule.
REQ-028 kbd_ready = !KRDY; kbd_valid & kbd_ready captures kbd_data and sets KRDY next edge.
REQ-029 dsp_valid = !DRDY; dsp_valid & dsp_ready sets DRDY next edge; dsp_data stable while dsp_valid.
REQ-030 KBDR-read commit and keyboard capture cannot coincide (kbd_ready=0 while KRDY=1); a byte offered the cycle after the clear SHALL be accepted.
REQ-031 kbd_irq = KRDY & KIE; dsp_irq = DRDY & DIE; both combinational from registers.
REQ-032 KBSR/DSR read returns status as it stands in the rdy cycle, including same-cycle side-port updates already registered.

Reset
REQ-033 arst_n low SHALL immediately force: FSM IDLE, rdy=0, rdata=0, KRDY=0, KIE=0, kbd byte=0, DRDY=1, DIE=0, dsp_data=0, MCR bit15=1.
REQ-034 Reset during BUSY SHALL abort the transaction with no rdy pulse and no side effect.
REQ-035 First init_txn is accepted in the first clock edge after arst_n deasserts.

Verification
REQ-036 LATENCY=3, read addr 0x02 after reset -> rdy high exactly 3 cycles after init_txn, rdata=16'h8000, one-cycle pulse.
REQ-037 kbd_valid with kbd_data=8'h41 -> kbd_ready drops; read KBSR -> 16'h8000; read KBDR -> 16'h0041, then kbd_ready=1, KBSR reads 16'h0000.
REQ-038 write DDR 16'h1234 -> dsp_valid=1, dsp_data=8'h34; second DDR write 16'h0055 before dsp_ready -> dsp_data stays 8'h34; dsp_ready pulse -> dsp_valid=0, DSR reads 16'h8000.
REQ-039 write KBSR 16'h4000 then keyboard byte -> kbd_irq=1; write DSR 16'h4000 -> dsp_irq=1 while DRDY=1.
REQ-040 write MCR 16'h0000 -> mcr_ce=0; read MCR -> 16'h0000; init_txn during BUSY -> single rdy only; arst_n low mid-BUSY -> no rdy, all REQ-033 values.
